// File: rtl/pico_pkg.sv
// Shared definitions for the pico core: PC-control modes, sequencer states
// and default widths used by the decoder and the PC sequencer.
package pico_pkg;

  localparam int unsigned PICO_W_PC        = 8;
  localparam int unsigned PICO_W_OFF       = 8;
  localparam int unsigned PICO_STACK_DEPTH = 4;

  typedef enum logic [1:0] {
    MODE_RETURN     = 2'd0,
    MODE_INCREMENT  = 2'd1,
    MODE_RELATIVE   = 2'd2,
    MODE_SUBROUTINE = 2'd3
  } mode_pc_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pico_pc_stack.sv
// LIFO return stack for the PC sequencer. The top entry is readable
// combinationally so a return completes in a single cycle.
module pico_pc_stack #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned DW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [DW-1:0] depth_o
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [DW-1:0] depth_r;
  logic [DW-1:0] top_s;

  assign top_s   = depth_r - DW'(1);
  assign data_o  = mem_r[top_s[AW-1:0]];
  assign full_o  = (depth_r == DW'(DEPTH));
  assign empty_o = (depth_r == DW'(0));
  assign depth_o = depth_r;

  // Occupancy counter; push and pop are mutually exclusive by construction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      depth_r <= DW'(0);
    end else if (push_i && !full_o) begin
      depth_r <= depth_r + DW'(1);
    end else if (pop_i && !empty_o) begin
      depth_r <= depth_r - DW'(1);
    end
  end

  // Entry storage carries no reset; contents below depth_r are meaningless.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) begin
      mem_r[depth_r[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/pico_pc_seq.sv
// Program-counter sequencer: next-PC mux, run/wait/halt FSM and return storage.
// PICO_PC_STACK_EN selects a LIFO return stack; otherwise a single link register.
module pico_pc_seq
  import pico_pkg::*;
#(
  parameter int unsigned W_PC        = PICO_W_PC,
  parameter int unsigned W_OFF       = PICO_W_OFF,
  parameter int unsigned STACK_DEPTH = PICO_STACK_DEPTH,
  parameter int unsigned RESET_VEC   = 0,
  localparam int unsigned W_DEP      = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [1:0]       mode_pc_i,
  input  logic [W_OFF-1:0] offset_i,
  input  logic [W_PC-1:0]  target_i,
  input  logic             halt_core_i,
  input  logic             wfi_core_i,
  output logic [W_PC-1:0]  pc_o,
  output logic             wait_o,
  output logic             halted_o,
  output logic             stk_ovf_o,
  output logic             stk_unf_o,
  output logic [W_DEP-1:0] depth_o
);

  localparam int unsigned W_EXT = (W_OFF > W_PC) ? W_OFF : W_PC;

  logic [W_PC-1:0]  pc_r, pc_nxt_s, pc_inc_s, off_s, pop_data_s;
  logic [W_EXT-1:0] off_ext_s;
  seq_state_e       state_r, state_nxt_s;
  mode_pc_e         mode_s;
  logic             ovf_r, ovf_nxt_s, unf_r, unf_nxt_s;
  logic             push_s, full_s, empty_s;
  logic [W_DEP-1:0] depth_s;

  assign mode_s    = mode_pc_e'(mode_pc_i);
  assign off_ext_s = W_EXT'($signed(offset_i));
  assign off_s     = off_ext_s[W_PC-1:0];
  assign pc_inc_s  = pc_r + W_PC'(1);

`ifdef PICO_PC_STACK_EN
  logic pop_s;

  pico_pc_stack #(
    .W     (W_PC),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_s && en_i),
    .pop_i   (pop_s && en_i),
    .data_i  (pc_inc_s),
    .data_o  (pop_data_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .depth_o (depth_s)
  );
`else
  logic [W_PC-1:0] link_r;
  logic            link_used_r;

  // Single link register; a return before any call lands on RESET_VEC.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      link_r      <= W_PC'(RESET_VEC);
      link_used_r <= 1'b0;
    end else if (en_i && push_s) begin
      link_r      <= pc_inc_s;
      link_used_r <= 1'b1;
    end
  end

  assign pop_data_s = link_r;
  assign full_s     = 1'b0;
  assign empty_s    = 1'b0;
  assign depth_s    = W_DEP'(link_used_r);
`endif

  // Next-state / next-PC: halt beats wfi beats the decoded PC mode.
  always_comb begin
    pc_nxt_s    = pc_r;
    state_nxt_s = state_r;
    ovf_nxt_s   = ovf_r;
    unf_nxt_s   = unf_r;
    push_s      = 1'b0;
`ifdef PICO_PC_STACK_EN
    pop_s       = 1'b0;
`endif
    case (state_r)
      ST_RUN: begin
        if (halt_core_i) begin
          state_nxt_s = ST_HALTED;
        end else if (wfi_core_i) begin
          state_nxt_s = ST_WAIT;
        end else begin
          case (mode_s)
            MODE_INCREMENT: pc_nxt_s = pc_inc_s;
            MODE_RELATIVE:  pc_nxt_s = pc_r + off_s;
            MODE_SUBROUTINE: begin
              if (full_s) begin
                ovf_nxt_s   = 1'b1;
                state_nxt_s = ST_HALTED;
              end else begin
                push_s   = 1'b1;
                pc_nxt_s = target_i;
              end
            end
            MODE_RETURN: begin
              if (empty_s) begin
                unf_nxt_s   = 1'b1;
                state_nxt_s = ST_HALTED;
              end else begin
`ifdef PICO_PC_STACK_EN
                pop_s    = 1'b1;
`endif
                pc_nxt_s = pop_data_s;
              end
            end
            default: state_nxt_s = ST_HALTED;
          endcase
        end
      end
      ST_WAIT: begin
        if (halt_core_i) begin
          state_nxt_s = ST_HALTED;
        end else if (!wfi_core_i) begin
          pc_nxt_s    = pc_inc_s;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_HALTED: state_nxt_s = ST_HALTED;
      default:   state_nxt_s = ST_HALTED;
    endcase
  end

  // Architectural state; en_i low freezes everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_r    <= W_PC'(RESET_VEC);
      state_r <= ST_RUN;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else if (en_i) begin
      pc_r    <= pc_nxt_s;
      state_r <= state_nxt_s;
      ovf_r   <= ovf_nxt_s;
      unf_r   <= unf_nxt_s;
    end
  end

  assign pc_o      = pc_r;
  assign wait_o    = (state_r == ST_WAIT);
  assign halted_o  = (state_r == ST_HALTED);
  assign stk_ovf_o = ovf_r;
  assign stk_unf_o = unf_r;
  assign depth_o   = depth_s;

endmodule

// File: doc/pico_pc_seq.md
# pico_pc_seq

Program-counter sequencer for the pico core. It consumes the decoder's `mode_pc`, `halt_core` and `wfi_core` controls and produces the registered fetch address. It also owns the subroutine return stack and the core run/wait/halt state machine. It sits between the decoder and the instruction memory address port, on the receiving end of the decoder's PC-control interface.

## Interface
- `W_PC`, 8: PC / address width.
- `W_OFF`, 8: branch offset width; the offset is two's complement.
- `STACK_DEPTH`, 4: number of return-stack entries; must be ≥1.
- `RESET_VEC`, 0: PC value after reset.

Ports:
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `en_i` in 1: advance enable. When low, all state is held.
- `mode_pc_i` in 2: PC mode from the decoder: RETURN=0, INCREMENT=1, RELATIVE=2, SUBROUTINE=3.
- `offset_i` in W_OFF: relative branch offset.
- `target_i` in W_PC: absolute subroutine target.
- `halt_core_i` in 1: halt request.
- `wfi_core_i` in 1: wait-for-interrupt request; high means no interrupt yet.
- `pc_o` out W_PC: current fetch address.
- `wait_o` out 1: core is in the WAIT state.
- `halted_o` out 1: core is in the HALTED state.
- `stk_ovf_o` out 1: sticky return-stack overflow.
- `stk_unf_o` out 1: sticky return-stack underflow.
- `depth_o` out $clog2(STACK_DEPTH+1): current stack occupancy.

## Operation
- States are RUN, WAIT and HALTED. Reset enters RUN.
- RUN: the input controls are evaluated in priority order `halt_core_i` > `wfi_core_i` > `mode_pc_i`.
  - `halt_core_i`: go to HALTED; PC is held. The decoder drives mode RETURN with HALT; that mode is ignored.
  - `wfi_core_i`: go to WAIT; PC is held.
  - INCREMENT: PC ← PC+1.
  - RELATIVE: PC ← PC + sign-extended `offset_i`.
  - SUBROUTINE: push PC+1; PC ← `target_i`.
  - RETURN: pop; PC ← the popped value.
- WAIT: PC is held while `wfi_core_i` is high. When `wfi_core_i` is low, PC ← PC+1 and the state returns to RUN. `halt_core_i` in WAIT moves to HALTED.
- HALTED: everything is held. The only exit is reset.
- Overflow: SUBROUTINE at depth == STACK_DEPTH.
  - No push and no jump; PC is held.
  - `stk_ovf_o` ← 1; state goes to HALTED.
- Underflow: RETURN at depth 0.
  - PC is held.
  - `stk_unf_o` ← 1; state goes to HALTED.
- `en_i` low freezes PC, stack and state regardless of the other inputs.
- Arithmetic:
  - All PC arithmetic is modulo 2^W_PC; wrap-around is silent (0xFF+1 → 0x00).
  - The offset is sign-extended to W_PC; if W_OFF > W_PC it is truncated to W_PC bits.

## Timing
- Every output is registered. Inputs are sampled on the rising `clk_i` edge; the new `pc_o` is visible the next cycle (latency 1).
- One instruction per enabled cycle; no bubbles on jumps, calls or returns.
- The path from `mode_pc_i`/`offset_i`/`target_i` to the next-PC logic is combinational. No input is registered internally.
- Reset values:
  - `pc_o`=RESET_VEC, `depth_o`=0.
  - `wait_o`, `halted_o`, `stk_ovf_o`, `stk_unf_o` = 0.
  - Stack contents are don't-care.
- Reset asserted mid-operation (including in WAIT or HALTED) takes effect immediately and clears the sticky flags.
- A push and a pop never occur in the same cycle.

## Configuration
- `PICO_PC_STACK_EN` defined: a STACK_DEPTH-entry LIFO return stack with the overflow/underflow handling above.
- Not defined: a single link register replaces the stack; STACK_DEPTH is ignored.
  - SUBROUTINE overwrites the link register and never overflows.
  - RETURN loads the link register and never underflows; after reset it returns to RESET_VEC.
  - `stk_ovf_o` and `stk_unf_o` are tied to 0. `depth_o` reads 1 after the first SUBROUTINE, otherwise 0.

## Structure
- `pico_pkg` holds:
  - the `mode_pc` enum (RETURN/INCREMENT/RELATIVE/SUBROUTINE);
  - the sequencer state enum (RUN/WAIT/HALTED);
  - shared widths.
- The decoder and this block both import those definitions.
- Sub-module `pico_pc_stack`: a LIFO with push/pop/data/full/empty/depth.
  - Instantiated only when `PICO_PC_STACK_EN` is defined.
  - The sequencer itself holds the state machine and next-PC mux.

## Test plan
Benches use W_PC=8, STACK_DEPTH=4.
- **Reset:** hold `rst_ni`=0 → `pc_o`=0x00 and all flags 0. Release, then 3× INCREMENT → `pc_o` 0x01, 0x02, 0x03.
- **Branch / wrap:**
  - At PC=0x10, RELATIVE with `offset_i`=0xFE → `pc_o`=0x0E.
  - At PC=0xFF, INCREMENT → `pc_o`=0x00.
- **Call / return:**
  - At PC=0x05, SUBROUTINE with `target_i`=0x40 → `pc_o`=0x40, `depth_o`=1.
  - Then RETURN → `pc_o`=0x06, `depth_o`=0.
- **Stack limits:**
  - Five nested SUBROUTINEs: after the 4th, `depth_o`=4. The 5th gives `stk_ovf_o`=1, `halted_o`=1, PC unchanged.
  - RETURN straight after reset → `stk_unf_o`=1, `halted_o`=1, `pc_o`=0x00.
- **WFI:**
  - At PC=0x20, hold `wfi_core_i`=1 for 5 cycles with mode INCREMENT → `pc_o` stays 0x20 and `wait_o`=1.
  - Drop `wfi_core_i` → `pc_o`=0x21 and `wait_o`=0.
- **Priority, enable and reset:**
  - `halt_core_i`=1 together with `wfi_core_i`=1 and mode RELATIVE → HALTED, PC held.
  - `en_i`=0 for 3 cycles → no change.
  - Assert `rst_ni` while HALTED → `pc_o`=0x00 and `halted_o`=0.
